// File: rtl/polar_sched_pkg.sv
// Shared types and helpers for the successive-cancellation LLR scheduler.
package polar_sched_pkg;

    localparam int LOG_N_DEFAULT = 10;
    localparam int N_DEFAULT     = 1 << LOG_N_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LLR  = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    // Trailing-zero count. Only ever called with a non-zero value
    // (the next bit index), so the all-zero result is never relied on.
    function automatic logic [7:0] ctz(input logic [31:0] v);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i[4:0]]) r = i[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_bit_index_counter.sv
// Bit-index counter for one codeword: clear, increment, terminal-count flag.
// The count saturates at all-ones so it can never wrap inside a codeword.
module sc_bit_index_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Clear wins over increment; increment is ignored at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = &r_count;

endmodule

// File: rtl/sc_llr_scheduler.sv
// SC polar decoder sequencer: walks bit indices 0..N-1, issuing f/g LLR
// operations stage by stage, then a decision request per bit.
//
//   state | meaning
//   IDLE  | waiting for start
//   LLR   | llr_op_valid high, walking stages down to 0
//   DEC   | dec_req high, waiting for dec_ack
//   DONE  | one-cycle done pulse, then IDLE
module sc_llr_scheduler
    import polar_sched_pkg::*;
#(
    parameter int LOG_N   = LOG_N_DEFAULT,
    parameter int STAGE_W = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               llr_op_valid,
    input  logic               llr_op_ready,
    output logic [STAGE_W-1:0] llr_op_stage,
    output logic               llr_op_is_g,
    output logic [LOG_N-1:0]   llr_op_bit_idx,
    output logic               dec_req,
    input  logic               dec_ack,
    output logic [LOG_N-1:0]   dec_bit_idx
);

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic [STAGE_W-1:0] r_stage;
    logic [STAGE_W-1:0] w_stage_nxt;
    logic               r_llr_valid;
    logic               r_dec_req;
    logic               r_is_g;
    logic               w_clr;
    logic               w_inc;
    logic               w_tc;
    logic [LOG_N-1:0]   w_bit_idx;
    logic [LOG_N-1:0]   w_bit_inc;
    logic [LOG_N-1:0]   w_bit_nxt;
    logic [STAGE_W-1:0] w_ctz_inc;

    sc_bit_index_counter #(
        .W (LOG_N)
    ) u_bit_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_count (w_bit_idx),
        .o_tc    (w_tc)
    );

    assign w_bit_inc = w_bit_idx + LOG_N'(1);
    assign w_ctz_inc = STAGE_W'(ctz(32'(w_bit_inc)));
    assign w_bit_nxt = w_clr ? '0 : (w_inc ? w_bit_inc : w_bit_idx);

    // Next-state, next-stage and counter control; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LLR;
                    w_stage_nxt = STAGE_W'(LOG_N - 1);
                    w_clr       = 1'b1;
                end
            end
            LLR: begin
                if (r_llr_valid && llr_op_ready) begin
                    if (r_stage == '0) w_state_nxt = DEC;
                    else               w_stage_nxt = r_stage - STAGE_W'(1);
                end
            end
            DEC: begin
                if (dec_ack) begin
                    if (w_tc) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LLR;
                        w_stage_nxt = w_ctz_inc;
                        w_inc       = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_stage_nxt = '0;
            w_clr       = 1'b1;
            w_inc       = 1'b0;
        end
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_stage     <= '0;
            r_llr_valid <= 1'b0;
            r_dec_req   <= 1'b0;
            r_is_g      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage     <= w_stage_nxt;
            r_llr_valid <= (w_state_nxt == LLR);
            r_dec_req   <= (w_state_nxt == DEC);
            r_is_g      <= (w_state_nxt == LLR) && w_bit_nxt[w_stage_nxt];
        end
    end

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign llr_op_valid   = r_llr_valid;
    assign llr_op_stage   = r_stage;
    assign llr_op_is_g    = r_is_g;
    assign llr_op_bit_idx = w_bit_idx;
    assign dec_req        = r_dec_req;
    assign dec_bit_idx    = w_bit_idx;

endmodule

// File: tb/tb_sc_llr_scheduler.sv
// Bench for sc_llr_scheduler: small (LOG_N=3) and full-size (LOG_N=10) instances.
module tb_sc_llr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start3, abort3, rdy3, ack3;
    logic       busy3, done3, v3, g3, req3;
    logic [1:0] st3;
    logic [2:0] b3, db3;

    logic       start10, abort10, rdy10, ack10;
    logic       busy10, done10, v10, g10, req10;
    logic [3:0] st10;
    logic [9:0] b10, db10;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_st[$];
    int exp_g[$];
    int exp_b[$];

    sc_llr_scheduler #(.LOG_N(3)) u3 (
        .clk(clk), .reset(rst_n), .start(start3), .abort(abort3),
        .busy(busy3), .done(done3), .llr_op_valid(v3), .llr_op_ready(rdy3),
        .llr_op_stage(st3), .llr_op_is_g(g3), .llr_op_bit_idx(b3),
        .dec_req(req3), .dec_ack(ack3), .dec_bit_idx(db3)
    );

    sc_llr_scheduler #(.LOG_N(10)) u10 (
        .clk(clk), .reset(rst_n), .start(start10), .abort(abort10),
        .busy(busy10), .done(done10), .llr_op_valid(v10), .llr_op_ready(rdy10),
        .llr_op_stage(st10), .llr_op_is_g(g10), .llr_op_bit_idx(b10),
        .dec_req(req10), .dec_ack(ack10), .dec_bit_idx(db10)
    );

    // Reference op list: bit 0 is f at every stage from the top; bit i>0 is one
    // g at stage ctz(i) followed by f down to stage 0.
    task automatic model_ops(input int logn);
        int t;
        exp_st.delete(); exp_g.delete(); exp_b.delete();
        for (int i = 0; i < (1 << logn); i++) begin
            if (i == 0) t = logn - 1;
            else begin
                t = 0;
                while (((i >> t) & 1) == 0) t++;
            end
            for (int s = t; s >= 0; s--) begin
                exp_st.push_back(s);
                exp_g.push_back((i != 0 && s == t) ? 1 : 0);
                exp_b.push_back(i);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start3 = 0; abort3 = 0; rdy3 = 1; ack3 = 1;
        start10 = 0; abort10 = 0; rdy10 = 0; ack10 = 0;
        repeat (3) @(negedge clk);
        n_chk++; if ({busy3, done3, v3, g3, req3} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl3: got %b expected 00000", {busy3, done3, v3, g3, req3});
        end
        n_chk++; if ({st3, b3, db3} !== 8'b0) begin
            n_fail++; $display("FAIL reset_payload3: got %h expected 0", {st3, b3, db3});
        end
        n_chk++; if ({busy10, done10, v10, g10, req10} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl10: got %b expected 00000", {busy10, done10, v10, g10, req10});
        end
        n_chk++; if ({st10, b10, db10} !== 24'b0) begin
            n_fail++; $display("FAIL reset_payload10: got %h expected 0", {st10, b10, db10});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ops = 0, decs = 0;
        model_ops(3);
        rdy3 = 1; ack3 = 1; start3 = 1;
        @(negedge clk); start3 = 0;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            n_chk++; if (busy3 !== (cyc <= 23)) begin
                n_fail++; $display("FAIL b2b_busy cyc %0d: got %b expected %b", cyc, busy3, (cyc <= 23));
            end
            n_chk++; if (done3 !== (cyc == 23)) begin
                n_fail++; $display("FAIL b2b_done cyc %0d: got %b expected %b", cyc, done3, (cyc == 23));
            end
            if (cyc <= 22) begin
                n_chk++; if ((v3 | req3) !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_bubble cyc %0d: got valid=%b req=%b expected one high", cyc, v3, req3);
                end
            end
            if (v3 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size()) begin
                    n_fail++; $display("FAIL b2b_extra_op: got op %0d expected at most %0d", ops, exp_st.size());
                end else if (32'(st3) !== 32'(exp_st[ops]) || 32'(g3) !== 32'(exp_g[ops]) || 32'(b3) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL b2b_op %0d: got st=%0d g=%0d b=%0d expected st=%0d g=%0d b=%0d",
                        ops, st3, g3, b3, exp_st[ops], exp_g[ops], exp_b[ops]);
                end
                ops++;
            end
            if (req3 === 1'b1) begin
                n_chk++; if (32'(db3) !== 32'(decs)) begin
                    n_fail++; $display("FAIL b2b_dec_idx: got %0d expected %0d", db3, decs);
                end
                decs++;
            end
            @(negedge clk);
        end
        n_chk++; if (ops != 14) begin n_fail++; $display("FAIL b2b_op_count: got %0d expected 14", ops); end
        n_chk++; if (decs != 8) begin n_fail++; $display("FAIL b2b_dec_count: got %0d expected 8", decs); end
    endtask

    task automatic test_ready_stall();
        int ops = 0, decs = 0, stalls = 0, held = 0, dcyc = -1, ndone = 0;
        model_ops(3);
        rdy3 = 1; ack3 = 1; start3 = 1;
        @(negedge clk); start3 = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (v3 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size()) begin
                    n_fail++; $display("FAIL stall_extra_op: got op %0d expected at most %0d", ops, exp_st.size());
                end else if (32'(st3) !== 32'(exp_st[ops]) || 32'(g3) !== 32'(exp_g[ops]) || 32'(b3) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL stall_op %0d: got st=%0d g=%0d b=%0d expected st=%0d g=%0d b=%0d",
                        ops, st3, g3, b3, exp_st[ops], exp_g[ops], exp_b[ops]);
                end
                if (b3 == 3'd4 && st3 == 2'd2) held++;
            end
            if (req3 === 1'b1) begin
                n_chk++; if (32'(db3) !== 32'(decs)) begin
                    n_fail++; $display("FAIL stall_dec_idx: got %0d expected %0d", db3, decs);
                end
                decs++;
            end
            if (done3 === 1'b1) begin dcyc = cyc; ndone++; end
            if (v3 === 1'b1 && b3 == 3'd4 && st3 == 2'd2 && stalls < 3) begin
                rdy3 = 0; stalls++;
            end else rdy3 = 1;
            if (v3 === 1'b1 && rdy3) ops++;
            @(negedge clk);
        end
        rdy3 = 1;
        n_chk++; if (held != 4) begin n_fail++; $display("FAIL stall_hold_cycles: got %0d expected 4", held); end
        n_chk++; if (dcyc != 26 || ndone != 1) begin
            n_fail++; $display("FAIL stall_done: got cycle %0d count %0d expected cycle 26 count 1", dcyc, ndone);
        end
        n_chk++; if (ops != 14 || decs != 8) begin
            n_fail++; $display("FAIL stall_counts: got ops %0d decs %0d expected 14 8", ops, decs);
        end
    endtask

    task automatic test_ack_delay();
        int ops = 0, decs = 0, waits = 0, reqcyc = 0, dcyc = -1;
        model_ops(3);
        rdy3 = 1; ack3 = 1; start3 = 1;
        @(negedge clk); start3 = 0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            if (v3 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size() || 32'(st3) !== 32'(exp_st[ops]) || 32'(g3) !== 32'(exp_g[ops]) || 32'(b3) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL ack_op %0d: got st=%0d g=%0d b=%0d", ops, st3, g3, b3);
                end
                ops++;
            end
            if (req3 === 1'b1) begin
                n_chk++; if (32'(db3) !== 32'(decs)) begin
                    n_fail++; $display("FAIL ack_dec_idx: got %0d expected %0d", db3, decs);
                end
                n_chk++; if (v3 !== 1'b0) begin
                    n_fail++; $display("FAIL ack_valid_during_req: got %b expected 0", v3);
                end
                if (db3 == 3'd3) reqcyc++;
            end
            if (done3 === 1'b1) dcyc = cyc;
            if (req3 === 1'b1 && db3 == 3'd3 && waits < 5) begin
                ack3 = 0; waits++;
            end else ack3 = 1;
            if (req3 === 1'b1 && ack3) decs++;
            @(negedge clk);
        end
        ack3 = 1;
        n_chk++; if (reqcyc != 6) begin n_fail++; $display("FAIL ack_hold_cycles: got %0d expected 6", reqcyc); end
        n_chk++; if (dcyc != 28) begin n_fail++; $display("FAIL ack_done_cycle: got %0d expected 28", dcyc); end
        n_chk++; if (ops != 14 || decs != 8) begin
            n_fail++; $display("FAIL ack_counts: got ops %0d decs %0d expected 14 8", ops, decs);
        end
    endtask

    task automatic test_abort();
        int ops = 0, ndone = 0, acyc = -1, at_dec, wait_cyc;
        model_ops(3);
        at_dec = $urandom_range(0, 1);
        rdy3 = 1; ack3 = 1; start3 = 1;
        @(negedge clk); start3 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done3 === 1'b1) ndone++;
            if (acyc < 0 && v3 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size() || 32'(st3) !== 32'(exp_st[ops]) || 32'(b3) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL abort_op %0d: got st=%0d b=%0d", ops, st3, b3);
                end
                ops++;
            end
            if (acyc >= 0 && cyc == acyc + 1) begin
                n_chk++; if ({busy3, v3, req3, done3} !== 4'b0) begin
                    n_fail++; $display("FAIL abort_idle: got busy/valid/req/done %b expected 0000", {busy3, v3, req3, done3});
                end
            end
            if (acyc >= 0 && cyc > acyc + 1) begin
                n_chk++; if (busy3 !== 1'b0) begin
                    n_fail++; $display("FAIL abort_stays_idle cyc %0d: got %b expected 0", cyc, busy3);
                end
            end
            if (acyc < 0 && ((at_dec != 0 && req3 === 1'b1 && db3 == 3'd5) ||
                             (at_dec == 0 && v3 === 1'b1 && b3 == 3'd5))) begin
                abort3 = 1; acyc = cyc;
            end else abort3 = 0;
            @(negedge clk);
        end
        abort3 = 0;
        n_chk++; if (acyc < 0 || ndone != 0) begin
            n_fail++; $display("FAIL abort_no_done: got abort cycle %0d done count %0d expected done count 0", acyc, ndone);
        end
        // start together with abort while idle must be honoured
        start3 = 1; abort3 = 1;
        @(negedge clk); start3 = 0; abort3 = 0;
        n_chk++; if ({busy3, v3, st3, g3, b3} !== {1'b1, 1'b1, 2'd2, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL abort_restart: got busy=%b v=%b st=%0d g=%b b=%0d expected 1 1 2 0 0", busy3, v3, st3, g3, b3);
        end
        ndone = 0; wait_cyc = 0;
        while (busy3 === 1'b1 && wait_cyc < 60) begin
            if (done3 === 1'b1) ndone++;
            wait_cyc++;
            @(negedge clk);
        end
        n_chk++; if (busy3 !== 1'b0 || ndone != 1) begin
            n_fail++; $display("FAIL abort_restart_done: got busy=%b done count %0d expected 0 1", busy3, ndone);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0, ops = 0, decs = 0, ndone = 0;
        rdy3 = 1; ack3 = 1; start3 = 1;
        @(negedge clk); start3 = 0;
        while (!(v3 === 1'b1 && b3 == 3'd6) && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        n_chk++; if (guard >= 40) begin n_fail++; $display("FAIL arst_reach_bit6: got timeout expected bit 6"); end
        rst_n = 0;
        #1;
        n_chk++; if ({busy3, done3, v3, g3, req3} !== 5'b0) begin
            n_fail++; $display("FAIL arst_ctl: got %b expected 00000", {busy3, done3, v3, g3, req3});
        end
        n_chk++; if ({st3, b3, db3} !== 8'b0) begin
            n_fail++; $display("FAIL arst_payload: got %h expected 0", {st3, b3, db3});
        end
        @(negedge clk);
        n_chk++; if (done3 !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b expected 0", done3); end
        rst_n = 1;
        @(negedge clk);
        model_ops(3);
        start3 = 1;
        @(negedge clk); start3 = 0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            n_chk++; if (busy3 !== (cyc <= 23)) begin
                n_fail++; $display("FAIL arst_busy cyc %0d: got %b expected %b", cyc, busy3, (cyc <= 23));
            end
            if (done3 === 1'b1) ndone++;
            if (v3 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size() || 32'(st3) !== 32'(exp_st[ops]) || 32'(g3) !== 32'(exp_g[ops]) || 32'(b3) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL arst_op %0d: got st=%0d g=%0d b=%0d", ops, st3, g3, b3);
                end
                ops++;
            end
            if (req3 === 1'b1) decs++;
            start3 = (cyc == 5 || cyc == 12 || cyc == 23);
            @(negedge clk);
        end
        start3 = 0;
        n_chk++; if (ops != 14 || decs != 8 || ndone != 1) begin
            n_fail++; $display("FAIL arst_counts: got ops %0d decs %0d done %0d expected 14 8 1", ops, decs, ndone);
        end
    endtask

    task automatic test_random_log10();
        int ops = 0, decs = 0, ndone = 0;
        logic pv = 0, pr = 0, pq = 0, pa = 0, finished = 0;
        model_ops(10);
        start10 = 1; rdy10 = 0; ack10 = 0;
        @(negedge clk); start10 = 0;
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            if (cyc > 1 && busy10 === 1'b0) begin finished = 1; break; end
            if (pv && !pr) begin
                n_chk++; if (v10 !== 1'b1) begin n_fail++; $display("FAIL rnd_valid_hold cyc %0d: got %b expected 1", cyc, v10); end
            end
            if (pq && !pa) begin
                n_chk++; if (req10 !== 1'b1) begin n_fail++; $display("FAIL rnd_req_hold cyc %0d: got %b expected 1", cyc, req10); end
            end
            if (v10 === 1'b1) begin
                n_chk++;
                if (ops >= exp_st.size()) begin
                    n_fail++; $display("FAIL rnd_extra_op: got op %0d expected at most %0d", ops, exp_st.size());
                end else if (32'(st10) !== 32'(exp_st[ops]) || 32'(g10) !== 32'(exp_g[ops]) || 32'(b10) !== 32'(exp_b[ops])) begin
                    n_fail++; $display("FAIL rnd_op %0d: got st=%0d g=%0d b=%0d expected st=%0d g=%0d b=%0d",
                        ops, st10, g10, b10, exp_st[ops], exp_g[ops], exp_b[ops]);
                end
            end
            if (req10 === 1'b1) begin
                n_chk++; if (32'(db10) !== 32'(decs)) begin
                    n_fail++; $display("FAIL rnd_dec_idx: got %0d expected %0d", db10, decs);
                end
            end
            if (done10 === 1'b1) ndone++;
            rdy10 = 1'($urandom_range(0, 1));
            ack10 = 1'($urandom_range(0, 1));
            if (v10 === 1'b1 && rdy10) ops++;
            if (req10 === 1'b1 && ack10) decs++;
            pv = v10; pr = rdy10; pq = req10; pa = ack10;
            @(negedge clk);
        end
        rdy10 = 0; ack10 = 0;
        n_chk++; if (!finished) begin n_fail++; $display("FAIL rnd_timeout: got still busy expected idle"); end
        n_chk++; if (ops != 2046) begin n_fail++; $display("FAIL rnd_op_count: got %0d expected 2046", ops); end
        n_chk++; if (decs != 1024) begin n_fail++; $display("FAIL rnd_dec_count: got %0d expected 1024", decs); end
        n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL rnd_done_count: got %0d expected 1", ndone); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ready_stall();
        test_ack_delay();
        test_abort();
        test_async_reset();
        test_random_log10();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
